sram_2rw_param: RTL
===================

Name: sram_2rw_param

Overview:
- Parametrised, synthesizable-behaviour model of a true dual-port (2RW) SRAM macro for the ASAP7 flow.
- Generalises the fixed 128x8 dual-port macro model in four ways: configurable width and depth, per-byte write mask, selectable same-port read/write mode, and an optional output pipeline register.
- Runs on a single clock, with a hardware clear sequencer started by reset.
- Used as the common memory model behind cache tag/data arrays and the generated SRAM wrappers.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
DEPTH, 256, number of words; need not be a power of 2.
ADDR_WIDTH, 8, address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
WRITE_FIRST, 0, same-port read+write policy: 0 = read-first (old data), 1 = write-first (merged new data).
OUT_REG, 0, 1 adds one output register stage.
INIT_VALUE, 0, DATA_WIDTH-wide word written to every location by the clear sequencer.

Ports:
CE  input  1  clock, rising edge active.
RST  input  1  asynchronous, active-high reset.
CSB1  input  1  port 1 chip select, active low.
WEB1  input  1  port 1 write enable, active low.
OEB1  input  1  port 1 read enable, active low.
A1  input  ADDR_WIDTH  port 1 address.
I1  input  DATA_WIDTH  port 1 write data.
WMASK1  input  DATA_WIDTH/8  port 1 byte-lane write mask, 1 = write lane.
O1  output  DATA_WIDTH  port 1 read data.
VALID1  output  1  port 1 read data valid, one-cycle pulse.
CSB2, WEB2, OEB2, A2, I2, WMASK2, O2, VALID2: port 2, identical to port 1.
INIT_BUSY  output  1  high while the clear sequencer runs.

Behaviour:
- RST asserted (asynchronous) forces the following immediately:
  - O1/O2 = 0, VALID1/VALID2 = 0, pipeline registers = 0.
  - INIT_BUSY = 1, clear counter = 0, FSM = CLEAR.
- FSM states CLEAR and READY:
  - CLEAR writes INIT_VALUE to address = counter on each CE edge after RST falls, then increments the counter.
  - On the edge that writes address DEPTH-1, the FSM moves to READY and INIT_BUSY drops to 0 after that edge.
  - A full clear takes exactly DEPTH cycles.
- While in CLEAR, all port requests are ignored: no writes, no VALID, O holds 0.
- RST asserted mid-CLEAR restarts the clear from address 0.
- Enable decode per port:
  - RE = ~CSB & ~OEB.
  - WE = ~CSB & ~WEB.
  - With CSB = 1 the port is idle and O holds its last value.
- Read latency is 1 + OUT_REG cycles:
  - The data is registered at the CE edge where RE is sampled (OUT_REG = 0), or one edge later (OUT_REG = 1).
  - VALID pulses high in the same cycle the new O appears.
  - Back-to-back reads give one result per cycle.
- Write takes effect at the CE edge. Lane k (bits 8k+7:8k) is written only if WMASK[k] = 1. WE with an all-zero mask is a no-op.
- Same-port RE and WE in the same cycle:
  - WRITE_FIRST = 0: O returns the pre-write word.
  - WRITE_FIRST = 1: O returns the stored word after the masked merge.
- Cross-port collisions, same address, same cycle:
  - Both write: per lane, port 1 wins where both masks are set; otherwise each masked lane takes its own port's data.
  - One port reads while the other writes: the reader always gets the pre-write word, regardless of WRITE_FIRST.
  - Both read: both get the same word.
- Address >= DEPTH: the write is ignored; the read returns all zeros with VALID asserted.
- Reset affects only control and output state. Memory contents are changed only by the clear sequencer.

Test Plan:
1. Reset and clear:
   - Stimulus: DEPTH = 256, INIT_VALUE = 32'hA5A5A5A5. Pulse RST, release.
   - Required: INIT_BUSY = 1 for exactly 256 cycles. Port 1 reads of A1 = 0 and A1 = 255 then return 32'hA5A5A5A5 with VALID1 one cycle after request.
2. Byte mask:
   - Stimulus: write A1 = 8'h10, I1 = 32'h11223344, WMASK1 = 4'hF; then write I1 = 32'hFFFFFFFF, WMASK1 = 4'b0101; then read.
   - Required: O1 = 32'h11FF33FF.
3. Same-port policy:
   - Stimulus: address 8'h20 holds 32'h0. Issue simultaneous read+write of 32'hDEADBEEF, full mask.
   - Required: O1 = 32'h0 with WRITE_FIRST = 0; O1 = 32'hDEADBEEF with WRITE_FIRST = 1. A following read returns 32'hDEADBEEF in both cases.
4. Cross-port collision:
   - Stimulus: same cycle, address 8'h30. Port 1 writes 32'hAAAAAAAA with WMASK1 = 4'b0011; port 2 writes 32'h55555555 with WMASK2 = 4'b0110.
   - Required: a later read gives 32'h0055AAAA, assuming a prior clear to 0.
5. OUT_REG = 1 pipeline:
   - Stimulus: reads of addresses 1, 2, 3 on consecutive cycles.
   - Required: O1 and VALID1 appear 2 cycles after each request, in order, with no bubbles.
6. Reset mid-clear and out-of-range:
   - Stimulus: assert RST at clear counter = 100; separately, with DEPTH = 200, write then read A1 = 8'd250.
   - Required: after RST the clear restarts at address 0 and INIT_BUSY lasts a full DEPTH cycles. The out-of-range write is ignored and the read returns 0 with VALID1 = 1.

Source files
------------

// File: rtl/sram_2rw_param.sv
// Parametrised true dual-port SRAM model with byte-lane write masks and a reset-started clear sequencer.
// Read latency is 1 + OUT_REG cycles. There is no backpressure: requests made while INIT_BUSY is high are dropped.
module sram_2rw_param #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    WRITE_FIRST = 0,
    parameter int                    OUT_REG     = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                    CE,
    input  logic                    RST,
    input  logic                    CSB1,
    input  logic                    WEB1,
    input  logic                    OEB1,
    input  logic [ADDR_WIDTH-1:0]   A1,
    input  logic [DATA_WIDTH-1:0]   I1,
    input  logic [DATA_WIDTH/8-1:0] WMASK1,
    output logic [DATA_WIDTH-1:0]   O1,
    output logic                    VALID1,
    input  logic                    CSB2,
    input  logic                    WEB2,
    input  logic                    OEB2,
    input  logic [ADDR_WIDTH-1:0]   A2,
    input  logic [DATA_WIDTH-1:0]   I2,
    input  logic [DATA_WIDTH/8-1:0] WMASK2,
    output logic [DATA_WIDTH-1:0]   O2,
    output logic                    VALID2,
    output logic                    INIT_BUSY
);

    localparam int                    NB        = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    csb   [2];
    logic                    web   [2];
    logic                    oeb   [2];
    logic [ADDR_WIDTH-1:0]   addr  [2];
    logic [DATA_WIDTH-1:0]   wdat  [2];
    logic [NB-1:0]           wmask [2];

    logic                    ready;
    logic                    re      [2];
    logic                    we      [2];
    logic                    in_rng  [2];
    logic [DATA_WIDTH-1:0]   bmask   [2];
    logic [DATA_WIDTH-1:0]   old_dat [2];
    logic [DATA_WIDTH-1:0]   rd_dat_q [2];
    logic [DATA_WIDTH-1:0]   rd_dat_d [2];
    logic                    rd_vld_q [2];
    logic                    rd_vld_d [2];

    assign csb[0]   = CSB1;   assign csb[1]   = CSB2;
    assign web[0]   = WEB1;   assign web[1]   = WEB2;
    assign oeb[0]   = OEB1;   assign oeb[1]   = OEB2;
    assign addr[0]  = A1;     assign addr[1]  = A2;
    assign wdat[0]  = I1;     assign wdat[1]  = I2;
    assign wmask[0] = WMASK1; assign wmask[1] = WMASK2;

    assign ready     = (state_q == ST_READY);
    assign INIT_BUSY = ~ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge CE or posedge RST) begin
        if (RST) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reads always see the pre-edge array; write-first only folds in the port's own write.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            bmask[p]    = '0;
            in_rng[p]   = ({1'b0, addr[p]} < DEPTH_W);
            re[p]       = ready & ~csb[p] & ~oeb[p];
            we[p]       = ready & ~csb[p] & ~web[p] & in_rng[p];
            for (int k = 0; k < NB; k++) begin
                bmask[p][8*k +: 8] = {8{wmask[p][k]}};
            end
            old_dat[p]  = in_rng[p] ? mem_q[addr[p]] : '0;
            rd_vld_d[p] = re[p];
            rd_dat_d[p] = rd_dat_q[p];
            if (re[p]) begin
                rd_dat_d[p] = old_dat[p];
                if ((WRITE_FIRST != 0) && we[p]) begin
                    rd_dat_d[p] = (old_dat[p] & ~bmask[p]) | (wdat[p] & bmask[p]);
                end
            end
        end
    end

    // Port 1 is applied last so it owns lanes that both ports write.
    always_ff @(posedge CE) begin
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= INIT_VALUE;
        end else begin
            for (int p = 1; p >= 0; p--) begin
                if (we[p]) begin
                    for (int k = 0; k < NB; k++) begin
                        if (wmask[p][k]) begin
                            mem_q[addr[p]][8*k +: 8] <= wdat[p][8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CE or posedge RST) begin
        if (RST) begin
            for (int p = 0; p < 2; p++) begin
                rd_dat_q[p] <= '0;
                rd_vld_q[p] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                rd_dat_q[p] <= rd_dat_d[p];
                rd_vld_q[p] <= rd_vld_d[p];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] o_dat_q [2];
            logic [DATA_WIDTH-1:0] o_dat_d [2];
            logic                  o_vld_q [2];
            logic                  o_vld_d [2];

            always_comb begin
                for (int p = 0; p < 2; p++) begin
                    o_vld_d[p] = rd_vld_q[p];
                    o_dat_d[p] = rd_vld_q[p] ? rd_dat_q[p] : o_dat_q[p];
                end
            end

            always_ff @(posedge CE or posedge RST) begin
                if (RST) begin
                    for (int p = 0; p < 2; p++) begin
                        o_dat_q[p] <= '0;
                        o_vld_q[p] <= 1'b0;
                    end
                end else begin
                    for (int p = 0; p < 2; p++) begin
                        o_dat_q[p] <= o_dat_d[p];
                        o_vld_q[p] <= o_vld_d[p];
                    end
                end
            end

            assign O1     = o_dat_q[0];
            assign VALID1 = o_vld_q[0];
            assign O2     = o_dat_q[1];
            assign VALID2 = o_vld_q[1];
        end else begin : g_noreg
            assign O1     = rd_dat_q[0];
            assign VALID1 = rd_vld_q[0];
            assign O2     = rd_dat_q[1];
            assign VALID2 = rd_vld_q[1];
        end
    endgenerate

endmodule
